// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1/8N2 UART transmitter for the angle-sensor command path.
// Latches one byte when send_en is high in IDLE and shifts it out LSB first.
// It pulses over_tx for one cycle after each completed frame.
module uart_byte_tx #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_en,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       over_tx
);

   localparam int unsigned      BAUD_DIV  = CLK_FREQ / BAUD;
   localparam int unsigned      CNT_W     = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
   logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic             r_stop_cnt, w_stop_cnt_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_tx, r_busy, r_over_tx;
   logic             w_tx_nxt, w_busy_nxt, w_over_tx_nxt;
   logic             w_baud_end;
   logic             w_last_stop;

   assign w_baud_end  = (r_baud_cnt == BAUD_LAST);
   // With one stop bit every stop-bit end is the last one.
   assign w_last_stop = r_stop_cnt | (STOP_BITS == 1);

   // State and datapath registers; reset wins on any edge, including mid-frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_over_tx  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         r_over_tx  <= w_over_tx_nxt;
      end
   end

   // Next-state and counter/shift-register update.
   always_comb begin
      w_state_nxt    = r_state;
      w_baud_cnt_nxt = r_baud_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_shift_nxt    = r_shift;
      case (r_state)
         IDLE: begin
            w_baud_cnt_nxt = '0;
            // Blocking on over_tx forces one idle cycle so the sequencer's
            // next byte is on data_in before it gets latched.
            if (send_en && !r_over_tx) begin
               w_state_nxt = START;
               w_shift_nxt = data_in;
            end
         end
         START: begin
            w_baud_cnt_nxt = w_baud_end ? '0 : r_baud_cnt + CNT_W'(1);
            if (w_baud_end) begin
               w_state_nxt   = DATA;
               w_bit_cnt_nxt = '0;
            end
         end
         DATA: begin
            w_baud_cnt_nxt = w_baud_end ? '0 : r_baud_cnt + CNT_W'(1);
            if (w_baud_end) begin
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt    = STOP;
                  w_stop_cnt_nxt = 1'b0;
               end
            end
         end
         STOP: begin
            w_baud_cnt_nxt = w_baud_end ? '0 : r_baud_cnt + CNT_W'(1);
            if (w_baud_end) begin
               w_stop_cnt_nxt = w_last_stop ? 1'b0 : ~r_stop_cnt;
               if (w_last_stop) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so the
   // registered outputs change on the same edge as the state.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
      w_busy_nxt    = (w_state_nxt != IDLE);
      w_over_tx_nxt = (r_state == STOP) && (w_state_nxt == IDLE);
   end

   assign tx      = r_tx;
   assign busy    = r_busy;
   assign over_tx = r_over_tx;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: self-checking bench for uart_byte_tx (BAUD_DIV=10), with
// one instance per stop-bit setting and a shared line decoder/scoreboard.
module tb_uart_byte_tx;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1, rst2 = 1'b1;
   logic       send_en = 1'b1, send_en2 = 1'b0;
   logic [7:0] data_in = 8'hA5, data_in2 = 8'h00;
   logic       tx, busy, over_tx;
   logic       tx2, busy2, over_tx2;

   int checks = 0;
   int errors = 0;

   // 0 selects the 1-stop-bit instance, 1 the 2-stop-bit instance
   logic sel = 1'b0;
   logic m_tx, m_busy, m_ov, m_rst;
   assign m_tx   = sel ? tx2 : tx;
   assign m_busy = sel ? busy2 : busy;
   assign m_ov   = sel ? over_tx2 : over_tx;
   assign m_rst  = sel ? rst2 : rst;

   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .send_en(send_en), .data_in(data_in),
      .tx(tx), .busy(busy), .over_tx(over_tx)
   );

   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst2), .send_en(send_en2), .data_in(data_in2),
      .tx(tx2), .busy(busy2), .over_tx(over_tx2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected bytes, pushed by the stimulus, popped by the decoder.
   logic [7:0] exp_q[$];

   // Line decoder: dcnt=1 is the first low cycle of a start bit.
   int         dcnt = 0;
   logic       in_fr = 1'b0;
   logic [7:0] acc = '0;
   int         samp = 0;
   int         last_ov_samp = 0;
   logic       gap_chk = 1'b0;
   int         done_cnt = 0;
   int         ov_cnt = 0;

   always @(negedge clk) begin
      int flen;
      samp++;
      flen = (sel ? 11 : 10) * DIV;
      if (m_rst === 1'b1) begin
         in_fr = 1'b0;
      end else if (!in_fr) begin
         if (m_ov === 1'b1) check("spurious_over_tx", 32'(m_ov), 32'd0);
         if (m_tx === 1'b0) begin
            in_fr = 1'b1;
            dcnt  = 1;
            acc   = '0;
            if (gap_chk) check("start_gap", 32'(samp - last_ov_samp), 32'd2);
         end
      end else begin
         dcnt++;
         if (dcnt == 5) check("start_mid", 32'(m_tx), 32'd0);
         else if (dcnt >= 11 && dcnt <= 90 && (dcnt % 10) == 5) acc = {m_tx, acc[7:1]};
         else if (dcnt > 90 && dcnt <= flen) check("stop_level", 32'(m_tx), 32'd1);
         if (dcnt == flen) begin
            check("busy_last_stop", 32'(m_busy), 32'd1);
            check("over_before_end", 32'(m_ov), 32'd0);
         end
         if (dcnt == flen + 1) begin
            check("over_tx_pulse", 32'(m_ov), 32'd1);
            check("busy_after", 32'(m_busy), 32'd0);
            ov_cnt++;
            last_ov_samp = samp;
            if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
            else check("decoded_byte", 32'(acc), 32'(exp_q.pop_front()));
            done_cnt++;
            in_fr = 1'b0;
         end else if (m_ov === 1'b1) begin
            check("early_over_tx", 32'(m_ov), 32'd0);
         end
      end
   end

   // Inputs change 1 time unit after the falling edge, clear of the decoder.
   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic set_in(input logic en, input logic [7:0] d);
      if (sel) begin send_en2 = en; data_in2 = d; end
      else     begin send_en  = en; data_in  = d; end
   endtask

   task automatic wait_frames(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 400) begin nxt(); n++; end
      if (done_cnt < target) check(name, 32'(done_cnt), 32'(target));
   endtask

   // Sequencer model: send_en held, next byte presented on each over_tx.
   task automatic seq_test(input logic s, input logic [31:0] bytes);
      int ov_base;
      int n;
      sel = s;
      ov_base = ov_cnt;
      gap_chk = 1'b0;
      set_in(1'b1, bytes[7:0]);
      exp_q.push_back(bytes[7:0]);
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (m_ov !== 1'b1 && n < 300) begin nxt(); n++; end
         if (m_ov !== 1'b1) check("seq_over_timeout", 32'(m_ov), 32'd1);
         if (k < 3) begin
            set_in(1'b1, bytes[8*(k+1) +: 8]);
            exp_q.push_back(bytes[8*(k+1) +: 8]);
            gap_chk = 1'b1;
         end else begin
            set_in(1'b0, bytes[31:24]);
            gap_chk = 1'b0;
         end
         nxt();
      end
      check("seq_over_count", 32'(ov_cnt - ov_base), 32'd4);
      for (int i = 0; i < 20; i++) begin
         nxt();
         if (m_tx !== 1'b1) check("seq_idle_tx", 32'(m_tx), 32'd1);
      end
      check("seq_idle_busy", 32'(m_busy), 32'd0);
   endtask

   typedef struct {
      logic       s;
      logic [7:0] data;
      int         late_cyc;
      logic [7:0] late_data;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] b;
      logic       e_tx;
      int         target;

      vecs[0] = '{1'b0, 8'h54, 30, 8'hFF, 8'h54};
      vecs[1] = '{1'b0, 8'h00, 0,  8'h00, 8'h00};
      vecs[2] = '{1'b0, 8'hFF, 50, 8'h00, 8'hFF};
      vecs[3] = '{1'b1, 8'h52, 0,  8'h00, 8'h52};
      vecs[4] = '{1'b1, 8'h01, 60, 8'h80, 8'h01};
      vecs[5] = '{1'b0, 8'h3C, 95, 8'hC3, 8'h3C};

      // Reset held with send_en high: line stays idle.
      for (int i = 0; i < 3; i++) begin
         nxt();
         check("rst_tx", 32'(tx), 32'd1);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_over", 32'(over_tx), 32'd0);
      end
      check("rst2_tx", 32'(tx2), 32'd1);
      rst = 1'b0; rst2 = 1'b0; send_en = 1'b0;
      nxt();
      check("post_rst_tx", 32'(tx), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_over", 32'(over_tx), 32'd0);
      nxt();

      // Single byte A5, checked cycle by cycle against the frame timing.
      sel = 1'b0;
      b = 8'hA5;
      target = done_cnt + 1;
      set_in(1'b1, b);
      exp_q.push_back(b);
      for (int c = 1; c <= 103; c++) begin
         nxt();
         if (c == 1) set_in(1'b0, b);
         if (c <= 10)      e_tx = 1'b0;
         else if (c <= 90) e_tx = b[(c - 11) / 10];
         else              e_tx = 1'b1;
         check("wave_tx", 32'(tx), 32'(e_tx));
         check("wave_busy", 32'(busy), 32'(c <= 100));
         check("wave_over", 32'(over_tx), 32'(c == 101));
      end
      wait_frames(target, "wave_frame_timeout");

      // Table of single frames, some with data_in changing mid-frame.
      foreach (vecs[i]) begin
         sel = vecs[i].s;
         target = done_cnt + 1;
         set_in(1'b1, vecs[i].data);
         exp_q.push_back(vecs[i].exp_byte);
         for (int c = 1; c < 300 && done_cnt < target; c++) begin
            nxt();
            if (c == 1) set_in(1'b0, vecs[i].data);
            if (c == vecs[i].late_cyc) set_in(1'b0, vecs[i].late_data);
         end
         if (done_cnt < target) check("vec_timeout", 32'(done_cnt), 32'(target));
         nxt(); nxt(); nxt();
      end

      // Back-to-back frames with the sequencer model, both stop-bit settings.
      seq_test(1'b0, {8'h52, 8'hA5, 8'h54, 8'hA5});
      seq_test(1'b1, {8'hA5, 8'h54, 8'hA5, 8'h52});

      // Reset mid-frame aborts without over_tx; a fresh frame follows.
      sel = 1'b0;
      set_in(1'b1, 8'hA5);
      exp_q.push_back(8'hA5);
      for (int c = 1; c <= 45; c++) begin
         nxt();
         if (c == 1) set_in(1'b0, 8'hA5);
      end
      check("pre_abort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      nxt();
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_over", 32'(over_tx), 32'd0);
      set_in(1'b1, 8'h3C);
      nxt();
      check("abort_hold_tx", 32'(tx), 32'd1);
      check("abort_hold_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      target = done_cnt + 1;
      exp_q.push_back(8'h3C);
      nxt();
      check("restart_tx", 32'(tx), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      set_in(1'b0, 8'h3C);
      wait_frames(target, "restart_timeout");
      nxt(); nxt();
      check("end_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
